// File: rtl/cla_share_arb_if.sv
// rtl/cla_share_arb_if.sv - request/response channels between two issue ports and the shared adder
interface cla_share_arb_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_sub;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_sub;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [RES_W-1:0]  rsp0_sum;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [RES_W-1:0]  rsp1_sum;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req0_ready, req1_ready,
    output rsp0_ready, rsp1_ready,
    input  rsp0_valid, rsp0_sum, rsp1_valid, rsp1_sum
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req0_ready, req1_ready,
    input  rsp0_ready, rsp1_ready,
    output rsp0_valid, rsp0_sum, rsp1_valid, rsp1_sum
  );
endinterface

// File: rtl/cla_share_arb.sv
// rtl/cla_share_arb.sv - round-robin share of one carry-lookahead adder between two requesters
module cla_share_arb #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  cla_share_arb_if.slave   bus,
  output logic             busy
);
  localparam int LVLS = $clog2(RES_W);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              sub_q, sub_d;
  logic [RES_W-1:0]  sum_q, sum_d;

  logic              grant0, grant1;
  logic [RES_W-1:0]  ext_a, ext_b, gen, prop, carry, cla_sum;
  logic [RES_W-1:0]  g_lvl [LVLS+1];
  logic [RES_W-1:0]  p_lvl [LVLS+1];

  // Parallel-prefix carry network; cin folds into bit 0 generate so subtract is ~B + 1.
  always_comb begin
    ext_a = {{(RES_W-DATA_W){a_q[DATA_W-1]}}, a_q};
    ext_b = {{(RES_W-DATA_W){b_q[DATA_W-1]}}, b_q} ^ {RES_W{sub_q}};
    gen   = ext_a & ext_b;
    prop  = ext_a ^ ext_b;
    g_lvl[0]    = gen;
    g_lvl[0][0] = gen[0] | (prop[0] & sub_q);
    p_lvl[0]    = prop;
    for (int l = 0; l < LVLS; l++) begin
      g_lvl[l+1] = g_lvl[l];
      p_lvl[l+1] = p_lvl[l];
      for (int i = (1 << l); i < RES_W; i++) begin
        g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-(1<<l)]);
        p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-(1<<l)];
      end
    end
    carry   = {g_lvl[LVLS][RES_W-2:0], sub_q};
    cla_sum = prop ^ carry;
  end

  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  prio_q);

  assign bus.req0_ready = (state_q == IDLE) & grant0 & ~rst;
  assign bus.req1_ready = (state_q == IDLE) & grant1 & ~rst;
  assign bus.rsp0_valid = (state_q == RESP) & ~owner_q & ~rst;
  assign bus.rsp1_valid = (state_q == RESP) &  owner_q & ~rst;
  assign bus.rsp0_sum   = sum_q;
  assign bus.rsp1_sum   = sum_q;
  assign busy           = (state_q != IDLE) & ~rst;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          owner_d = 1'b0;
          a_d     = bus.req0_a;
          b_d     = bus.req0_b;
          sub_d   = bus.req0_sub;
          state_d = EXEC;
        end else if (grant1) begin
          owner_d = 1'b1;
          a_d     = bus.req1_a;
          b_d     = bus.req1_b;
          sub_d   = bus.req1_sub;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = cla_sum;
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
    end
  end
endmodule
